teclado_matricial: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces presses and encodes each key as a BCD nibble.

---
 rtl/teclado_matricial_if.sv | 16 +
 rtl/teclado_matricial.sv | 263 ++++++++++++++++++++++++++
 tb/tb_teclado_matricial.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/teclado_matricial_if.sv
// rtl/teclado_matricial_if.sv - digit-buffer output bundle of the 4x4 keypad scanner
// Purpose: carries the BCD digit buffer and its one-cycle accept strobe from
//          teclado_matricial to its consumer.
// Signals:
//   digitos_value  80  twenty BCD nibbles, [3:0] = newest digit, 4'hF = empty slot
//   digitos_valid   1  one-cycle pulse per accepted key
// Modports:
//   master  drives digitos_value / digitos_valid (keypad scanner)
//   slave   receives them (consumer)
interface teclado_matricial_if;
  logic [79:0] digitos_value;
  logic        digitos_valid;

  modport master (output digitos_value, output digitos_valid);
  modport slave  (input  digitos_value, input  digitos_valid);
endinterface

// File: rtl/teclado_matricial.sv
// rtl/teclado_matricial.sv - 4x4 matrix keypad scanner, debouncer and BCD digit buffer
// Purpose: drives the keypad columns one at a time, debounces a single pressed key,
//          encodes it as BCD and shifts it into a 20-digit buffer with a one-cycle strobe.
// Ports:
//   clk           in   1   system clock
//   rst           in   1   synchronous active-high reset
//   teclado_en_i  in   1   enable; low = idle with the buffer cleared
//   lin_i         in   4   keypad rows, active-high, asynchronous to clk
//   col_o         out  4   keypad column drive, one-hot active-high (4'b1111 while
//                          waiting for release, 4'b0000 when disabled)
//   dig_o         master  teclado_matricial_if (digitos_value / digitos_valid)
// Parameters: SCAN_CYCLES (>=3), DEBOUNCE_CYCLES, TIMEOUT_CYCLES.
// Optional feature: define TECLADO_TIMEOUT_EN to discard a partial entry after
//   TIMEOUT_CYCLES idle cycles.
module teclado_matricial #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                teclado_en_i,
  input  logic [3:0]          lin_i,
  output logic [3:0]          col_o,
  teclado_matricial_if.master dig_o
);

  if (SCAN_CYCLES < 3 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("teclado_matricial: invalid parameter set");
  end

  localparam int SCW = $clog2(SCAN_CYCLES);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [79:0]    EMPTY     = '1;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     lin_s1_q, lin_s2_q;
  logic [1:0]     col_idx_q, col_idx_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]     row_q, row_d;
  logic [79:0]    digits_q, digits_d;
  logic           valid_q, valid_d;
  logic           term_q, term_d;

  logic [3:0]     lin_sync;
  logic           lin_one, lin_many;
  logic [1:0]     row_idx;
  logic           key_mapped;
  logic [3:0]     key_code;

  assign lin_sync = lin_s2_q;
  assign lin_one  = (lin_sync != 4'd0) && ((lin_sync & (lin_sync - 4'd1)) == 4'd0);
  assign lin_many = (lin_sync != 4'd0) && !lin_one;

  // The latched row is kept one-hot so the debouncer can compare it directly
  // against the synchronized rows; the index is only needed for encoding.
  always_comb begin
    row_idx = 2'd0;
    case (row_q)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Row-major layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  // Letter keys (column 3) are debounced like any other key but never emitted.
  always_comb begin
    key_mapped = 1'b1;
    key_code   = 4'hF;
    case ({row_idx, col_idx_q})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b11_00: key_code = 4'hA;
      4'b11_01: key_code = 4'h0;
      4'b11_10: key_code = 4'hB;
      default:  key_mapped = 1'b0;
    endcase
  end

`ifdef TECLADO_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
  logic [TOW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    row_d      = row_q;
    digits_d   = digits_q;
    valid_d    = 1'b0;
    term_d     = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
    idle_d     = idle_q;
`endif

    case (state_q)
      ST_SCAN: begin
        // Decide only on the last cycle of a column so the two-flop
        // synchronizer has settled on rows belonging to this column.
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
          if (lin_one) begin
            row_d   = lin_sync;
            state_d = ST_DEBOUNCE;
          end else if (lin_many) begin
            state_d = ST_WAIT_RELEASE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCW'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (lin_sync == row_q) begin
          if (deb_cnt_q == DEB_LAST) begin
            // Buffer and strobe are registered here so they become visible
            // together during the EMIT cycle.
            deb_cnt_d = '0;
            state_d   = ST_EMIT;
            if (key_mapped) begin
              digits_d = {digits_q[75:0], key_code};
              valid_d  = 1'b1;
              term_d   = (key_code == 4'hA) || (key_code == 4'hB);
            end
          end else begin
            deb_cnt_d = deb_cnt_q + DBW'(1);
          end
        end else begin
          deb_cnt_d = '0;
          state_d   = ST_SCAN;
        end
      end

      ST_EMIT: begin
        deb_cnt_d = '0;
        state_d   = ST_WAIT_RELEASE;
        // A terminator is shown for its strobe cycle only, then the entry is dropped.
        if (term_q) begin
          digits_d = EMPTY;
        end
      end

      ST_WAIT_RELEASE: begin
        if (lin_sync == 4'd0) begin
          if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_d  = '0;
            scan_cnt_d = '0;
            col_idx_d  = 2'd0;
            state_d    = ST_SCAN;
          end else begin
            deb_cnt_d = deb_cnt_q + DBW'(1);
          end
        end else begin
          deb_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase

`ifdef TECLADO_TIMEOUT_EN
    if (valid_d) begin
      idle_d = '0;
    end else if (digits_q != EMPTY) begin
      if (idle_q == TO_LAST) begin
        idle_d   = '0;
        digits_d = EMPTY;
      end else begin
        idle_d = idle_q + TOW'(1);
      end
    end else begin
      idle_d = '0;
    end
`endif

    if (!teclado_en_i) begin
      state_d    = ST_SCAN;
      col_idx_d  = 2'd0;
      scan_cnt_d = '0;
      deb_cnt_d  = '0;
      digits_d   = EMPTY;
      valid_d    = 1'b0;
      term_d     = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
      idle_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      lin_s1_q   <= 4'd0;
      lin_s2_q   <= 4'd0;
      col_idx_q  <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      row_q      <= 4'd0;
      digits_q   <= EMPTY;
      valid_q    <= 1'b0;
      term_q     <= 1'b0;
`ifdef TECLADO_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lin_s1_q   <= lin_i;
      lin_s2_q   <= lin_s1_q;
      col_idx_q  <= col_idx_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      row_q      <= row_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      term_q     <= term_d;
`ifdef TECLADO_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  // All columns are driven while waiting for release so any held key is seen.
  always_comb begin
    if (!teclado_en_i) begin
      col_o = 4'b0000;
    end else if (state_q == ST_WAIT_RELEASE) begin
      col_o = 4'b1111;
    end else begin
      col_o = 4'b0001 << col_idx_q;
    end
  end

  assign dig_o.digitos_value = digits_q;
  assign dig_o.digitos_valid = valid_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// tb/tb_teclado_matricial.sv - directed self-checking bench for teclado_matricial
`timescale 1ns/1ps
module tb_teclado_matricial;
  localparam int SCAN = 4;
  localparam int DEB  = 8;
  localparam int TO   = 200;
  localparam logic [79:0] ALL_F = {80{1'b1}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [15:0] keys = 16'h0;
  logic [3:0]  lin;
  logic [3:0]  col;

  int n_cmp = 0;
  int n_err = 0;

  int          pulses = 0;
  logic [79:0] last_val = '0;
  logic [79:0] after_val = '0;
  logic        prev_v = 1'b0;

  int          base;
  int          lat;
  logic [79:0] snap;

  teclado_matricial_if dig ();

  teclado_matricial #(
    .SCAN_CYCLES    (SCAN),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .teclado_en_i(en),
    .lin_i       (lin),
    .col_o       (col),
    .dig_o       (dig)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its driven column to its row.
  always_comb begin
    lin = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c]) lin[r] = 1'b1;
  end

  always @(negedge clk) begin
    if (prev_v) after_val = dig.digitos_value;
    prev_v = dig.digitos_valid;
    if (dig.digitos_valid) begin
      pulses++;
      last_val = dig.digitos_value;
    end
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int r, input int c);
    keys[r*4+c] = 1'b1;
    cyc(40);
    keys[r*4+c] = 1'b0;
    cyc(20);
  endtask

  task automatic digit(input int d);
    if (d == 0) tap(3, 1);
    else        tap((d - 1) / 3, (d - 1) % 3);
  endtask

  initial begin
    // Reset state, key '1' already held
    keys[0] = 1'b1;
    cyc(3);
    chk("rst_value", dig.digitos_value, ALL_F);
    chk("rst_valid", {79'd0, dig.digitos_valid}, 80'd0);
    chk("rst_col",   {76'd0, col}, 80'h1);

    // Exact latency from reset release: 4 scan + 8 debounce cycles
    rst = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (dig.digitos_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 80'(lat), 80'd12);
    chk("first_key", dig.digitos_value, {{19{4'hF}}, 4'h1});

    // Reset in the middle of WAIT_RELEASE
    keys[0] = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(2);
    chk("midrst_value", dig.digitos_value, ALL_F);
    chk("midrst_col",   {76'd0, col}, 80'h1);
    rst = 1'b0;
    cyc(15);

    // Test 1: single '5'
    base = pulses;
    tap(1, 1);
    chk("t1_pulses", 80'(pulses - base), 80'd1);
    chk("t1_value",  last_val, {{19{4'hF}}, 4'h5});

    // Test 2: 1 2 3 4 * with terminator clear
    base = pulses;
    digit(1); digit(2); digit(3); digit(4);
    tap(3, 0);
    chk("t2_pulses", 80'(pulses - base), 80'd5);
    chk("t2_value",  last_val, {{14{4'hF}}, 24'h51234A});
    chk("t2_after",  after_val, ALL_F);
    chk("t2_idle",   dig.digitos_value, ALL_F);

    // Test 3: bouncing '9', then stable
    base = pulses;
    for (int i = 0; i < 10; i++) begin
      keys[10] = (i % 2 == 0);
      cyc(3);
    end
    keys[10] = 1'b1;
    cyc(40);
    keys[10] = 1'b0;
    cyc(20);
    chk("t3_pulses", 80'(pulses - base), 80'd1);
    chk("t3_value",  last_val, {{19{4'hF}}, 4'h9});

    // Test 4: 1 and 4 together, then '7'
    base = pulses;
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    cyc(40);
    keys[0] = 1'b0;
    keys[4] = 1'b0;
    cyc(20);
    chk("t4_multi", 80'(pulses - base), 80'd0);
    digit(7);
    chk("t4_pulses", 80'(pulses - base), 80'd1);
    chk("t4_value",  last_val, {{18{4'hF}}, 8'h97});

    // Test 5: 21 digits overflow, then letter 'A'
    base = pulses;
    for (int i = 0; i < 21; i++) digit((i < 20) ? (i % 10) : 3);
    chk("t5_pulses", 80'(pulses - base), 80'd21);
    chk("t5_value",  dig.digitos_value, 80'h12345678901234567893);
    base = pulses;
    tap(0, 3);
    chk("t5_letter", 80'(pulses - base), 80'd0);
    chk("t5_keep",   dig.digitos_value, 80'h12345678901234567893);

    // Test 6a: disable clears buffer, re-enable starts at column 0
    en = 1'b0;
    cyc(1);
    chk("t6_dis_col",   {76'd0, col}, 80'h0);
    chk("t6_dis_value", dig.digitos_value, ALL_F);
    chk("t6_dis_valid", {79'd0, dig.digitos_valid}, 80'd0);
    en = 1'b1;
    cyc(1);
    chk("t6_reen_col",  {76'd0, col}, 80'h1);

    // Test 6b: disable for one cycle mid-DEBOUNCE aborts the key
    rst = 1'b1;
    keys[0] = 1'b1;
    cyc(2);
    rst = 1'b0;
    base = pulses;
    cyc(6);
    en = 1'b0;
    keys[0] = 1'b0;
    cyc(1);
    chk("t6_abort_col", {76'd0, col}, 80'h0);
    en = 1'b1;
    cyc(40);
    chk("t6_abort_pulses", 80'(pulses - base), 80'd0);
    chk("t6_abort_value",  dig.digitos_value, ALL_F);

    // Test 6c: idle timeout behaviour
    digit(2);
    digit(5);
    snap = {{18{4'hF}}, 8'h25};
    chk("t6_two", dig.digitos_value, snap);
    base = pulses;
    cyc(TO);
`ifdef TECLADO_TIMEOUT_EN
    chk("t6_timeout_value", dig.digitos_value, ALL_F);
`else
    chk("t6_kept_value", dig.digitos_value, snap);
`endif
    chk("t6_timeout_pulses", 80'(pulses - base), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
